// File: rtl/restoring_div_pkg.sv
// rtl/restoring_div_pkg.sv - shared types and constants for the restoring divider
package restoring_div_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/div_control.sv
// rtl/div_control.sv - sequencing FSM and step counter for the restoring divider
module div_control
  import restoring_div_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   run_edge,
  input  logic   run_level,
  input  logic   div_zero,
  output logic   load_en,
  output logic   start_en,
  output logic   step_en,
  output logic   zero_flag_set,
  output state_t state
);

  state_t     next_state;
  logic [2:0] step_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_cnt <= '0;
    end else begin
      state <= next_state;
      if (start_en) begin
        step_cnt <= '0;
      end else if (step_en) begin
        step_cnt <= step_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    next_state    = state;
    load_en       = 1'b0;
    start_en      = 1'b0;
    step_en       = 1'b0;
    zero_flag_set = 1'b0;
    unique case (state)
      IDLE: begin
        // A load held in the same cycle as a run edge swallows the edge.
        if (load) begin
          load_en = 1'b1;
        end else if (run_edge) begin
          if (div_zero) begin
            zero_flag_set = 1'b1;
            next_state    = HOLD;
          end else begin
            start_en   = 1'b1;
            next_state = DIV;
          end
        end
      end
      DIV: begin
        step_en = 1'b1;
        if (step_cnt == 3'd7) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (!run_level) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/restoring_div.sv
// rtl/restoring_div.sv - 8-bit unsigned restoring divider with button inputs and hex display
module restoring_div
  import restoring_div_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ClearA_LoadB,
  input  logic       Run,
  input  logic [7:0] S,
  output logic [6:0] AhexU,
  output logic [6:0] AhexL,
  output logic [6:0] BhexU,
  output logic [6:0] BhexL,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       X
);

  logic [SYNC_STAGES-1:0]             load_sync;
  logic [SYNC_STAGES-1:0]             run_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] s_sync;

  logic              load, run_level, run_prev, run_edge;
  logic [DATA_W-1:0] s_val;
  logic              load_en, start_en, step_en, zero_flag_set;
  state_t            state;

  logic [DATA_W-1:0] a_reg, b_reg, d_reg;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic              fits;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      load_sync <= '0;
      run_sync  <= '0;
      s_sync    <= '0;
      run_prev  <= 1'b0;
    end else begin
      load_sync[0] <= ClearA_LoadB;
      run_sync[0]  <= Run;
      s_sync[0]    <= S;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        load_sync[i] <= load_sync[i-1];
        run_sync[i]  <= run_sync[i-1];
        s_sync[i]    <= s_sync[i-1];
      end
      run_prev <= run_level;
    end
  end

  assign load      = ~load_sync[SYNC_STAGES-1];
  assign run_level = ~run_sync[SYNC_STAGES-1];
  assign s_val     = s_sync[SYNC_STAGES-1];
  assign run_edge  = run_level & ~run_prev;

  div_control u_ctrl (
    .clk          (Clk),
    .rst_n        (Reset),
    .load         (load),
    .run_edge     (run_edge),
    .run_level    (run_level),
    .div_zero     (s_val == '0),
    .load_en      (load_en),
    .start_en     (start_en),
    .step_en      (step_en),
    .zero_flag_set(zero_flag_set),
    .state        (state)
  );

  // The partial remainder stays below the divisor, so its ninth bit is always
  // zero and a_reg holds the whole of it; the low byte of the subtraction is exact.
  assign trial = {a_reg, b_reg[DATA_W-1]};
  assign fits  = trial >= {1'b0, d_reg};
  assign diff  = trial[DATA_W-1:0] - d_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_reg <= '0;
      b_reg <= '0;
      d_reg <= '0;
      X     <= 1'b0;
    end else if (load_en) begin
      b_reg <= s_val;
      a_reg <= '0;
      X     <= 1'b0;
    end else if (zero_flag_set) begin
      d_reg <= s_val;
      X     <= 1'b1;
    end else if (start_en) begin
      d_reg <= s_val;
      a_reg <= '0;
      X     <= 1'b0;
    end else if (step_en && state == DIV) begin
      if (fits) begin
        a_reg <= diff;
        b_reg <= {b_reg[DATA_W-2:0], 1'b1};
      end else begin
        a_reg <= trial[DATA_W-1:0];
        b_reg <= {b_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign Aval  = a_reg;
  assign Bval  = b_reg;
  assign AhexU = hex_to_seg(a_reg[7:4]);
  assign AhexL = hex_to_seg(a_reg[3:0]);
  assign BhexU = hex_to_seg(b_reg[7:4]);
  assign BhexL = hex_to_seg(b_reg[3:0]);

endmodule

// File: tb/tb_restoring_div.sv
// tb/tb_restoring_div.sv - directed self-checking bench for restoring_div
module tb_restoring_div;
  import restoring_div_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, ClearA_LoadB, Run;
  logic [7:0] S;
  logic [6:0] AhexU, AhexL, BhexU, BhexL;
  logic [7:0] Aval, Bval;
  logic       X;

  int         checks = 0;
  int         passed = 0;
  int         div_cycles;
  logic       seen_hold, found;
  logic [7:0] hold_a, hold_b;
  logic       hold_x;

  always #5 Clk = ~Clk;

  restoring_div #(.SYNC_STAGES(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ClearA_LoadB(ClearA_LoadB),
    .Run         (Run),
    .S           (S),
    .AhexU       (AhexU),
    .AhexL       (AhexL),
    .BhexU       (BhexU),
    .BhexL       (BhexL),
    .Aval        (Aval),
    .Bval        (Bval),
    .X           (X)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load_op(input logic [7:0] v);
    S = v;
    ClearA_LoadB = 1'b0;
    repeat (6) @(posedge Clk);
    #1 ClearA_LoadB = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] v, input int hold_cyc);
    S = v;
    repeat (4) @(posedge Clk);
    #1 Run = 1'b0;
    div_cycles = 0;
    seen_hold  = 1'b0;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge Clk);
      if (dut.state == DIV) div_cycles++;
      if (!seen_hold && dut.state == HOLD) begin
        seen_hold = 1'b1;
        hold_a    = Aval;
        hold_b    = Bval;
        hold_x    = X;
      end
    end
    Run = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0; ClearA_LoadB = 1'b1; Run = 1'b1; S = 8'h00;
    hold_a = '0; hold_b = '0; hold_x = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_aval", Aval, 8'h00);
    check("rst_bval", Bval, 8'h00);
    check("rst_x", {7'd0, X}, 8'h00);
    check("rst_ahexl", {1'b0, AhexL}, 8'h40);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    check("post_rst_ahexu", {1'b0, AhexU}, 8'h40);
    check("post_rst_bhexu", {1'b0, BhexU}, 8'h40);
    check("post_rst_bhexl", {1'b0, BhexL}, 8'h40);
    check("post_rst_state", {6'd0, dut.state}, {6'd0, IDLE});

    // 100 / 7 = 14 r 2
    load_op(8'h64);
    check("load64_b", Bval, 8'h64);
    check("load64_a", Aval, 8'h00);
    run_op(8'h07, 20);
    check("d7_div_cycles", div_cycles[7:0], 8'd8);
    check("d7_seen_hold", {7'd0, seen_hold}, 8'h01);
    check("d7_hold_b", hold_b, 8'h0E);
    check("d7_hold_a", hold_a, 8'h02);
    check("d7_hold_x", {7'd0, hold_x}, 8'h00);
    check("d7_ahexl", {1'b0, AhexL}, 8'h24);
    check("d7_bhexl", {1'b0, BhexL}, 8'h06);
    check("d7_bhexu", {1'b0, BhexU}, 8'h40);

    // Long press: 14 / 3 = 4 r 2, once only; then 4 / 2 = 2 r 0
    run_op(8'h03, 30);
    check("d3_div_cycles", div_cycles[7:0], 8'd8);
    check("d3_b", Bval, 8'h04);
    check("d3_a", Aval, 8'h02);
    run_op(8'h02, 20);
    check("d2_b", Bval, 8'h02);
    check("d2_a", Aval, 8'h00);
    check("d2_idle", {6'd0, dut.state}, {6'd0, IDLE});

    // 255 / 1 and 5 / 255
    load_op(8'hFF);
    run_op(8'h01, 20);
    check("ff_by_1_b", Bval, 8'hFF);
    check("ff_by_1_a", Aval, 8'h00);
    check("ff_by_1_bhexu", {1'b0, BhexU}, 8'h0E);
    load_op(8'h05);
    run_op(8'hFF, 20);
    check("5_by_ff_b", Bval, 8'h00);
    check("5_by_ff_a", Aval, 8'h05);
    check("5_by_ff_ahexl", {1'b0, AhexL}, 8'h12);

    // Divide by zero
    load_op(8'h10);
    run_op(8'h00, 20);
    check("dz_div_cycles", div_cycles[7:0], 8'd0);
    check("dz_hold_x", {7'd0, hold_x}, 8'h01);
    check("dz_hold_a", hold_a, 8'h00);
    check("dz_hold_b", hold_b, 8'h10);
    check("dz_x_sticky", {7'd0, X}, 8'h01);

    // Load and run pressed together: load wins
    S = 8'h33;
    repeat (4) @(posedge Clk);
    #1 ClearA_LoadB = 1'b0; Run = 1'b0;
    div_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (dut.state == DIV) div_cycles++;
    end
    ClearA_LoadB = 1'b1; Run = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    check("both_div_cycles", div_cycles[7:0], 8'd0);
    check("both_b", Bval, 8'h33);
    check("both_a", Aval, 8'h00);
    check("both_x", {7'd0, X}, 8'h00);

    // Reset in the 4th DIV cycle
    load_op(8'h64);
    S = 8'h07;
    repeat (4) @(posedge Clk);
    #1 Run = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      if (dut.state == DIV) found = 1'b1;
    end
    check("mid_reach_div", {7'd0, found}, 8'h01);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("mid_rst_a", Aval, 8'h00);
    check("mid_rst_b", Bval, 8'h00);
    check("mid_rst_x", {7'd0, X}, 8'h00);
    check("mid_rst_state", {6'd0, dut.state}, {6'd0, IDLE});
    @(negedge Clk);
    Reset = 1'b1;
    div_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (dut.state == DIV) div_cycles++;
    end
    Run = 1'b1;
    repeat (6) @(negedge Clk);
    check("mid_no_resume", div_cycles[7:0], 8'd0);
    check("mid_final_b", Bval, 8'h00);
    check("mid_final_a", Aval, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
